// File: rtl/set_assoc_wb_cache.sv
// set_assoc_wb_cache
// N-way set-associative, write-back, write-allocate cache. One line holds one
// word. A core-side valid/ready request port sits in front of a single-word
// backing memory port that uses a req/ack handshake.
//
// Optional feature macro: CACHE_STATS_EN. When it is defined, the module has
// saturating 32-bit hit, miss and writeback counters.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready     core request handshake (ready only in IDLE)
//   req_we/addr/wdata       request: write enable, word address, write data
//   resp_valid/resp_rdata   one-cycle completion pulse with the line word
//   mem_req/we/addr/wdata   backing memory request (held until mem_ack)
//   mem_rdata/mem_ack       refill data, sampled on the one-cycle ack
//   stat_hits/misses/wbacks statistics (CACHE_STATS_EN only)
module set_assoc_wb_cache #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int SETS   = 256,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses,
  output logic [31:0]       stat_wbacks
`endif
);

  localparam int SET_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - SET_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WB     = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [WAYS-1:0]   dirty    [SETS];
  logic [WAY_W-1:0]  rr       [SETS];

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [WAY_W-1:0]  victim_q;

  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  tag;
  logic [WAYS-1:0]   set_valid;
  logic [WAYS-1:0]   set_dirty;
  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              victim_dirty;
  logic              all_valid;
  logic [WAY_W-1:0]  rr_next;

  assign req_ready = (state == S_IDLE);
  assign set_idx   = addr_q[SET_W-1:0];
  assign tag       = addr_q[ADDR_W-1:SET_W];

  // Tag compare across the set and victim choice. The descending scan leaves
  // the lowest-index invalid way as victim; only a full set uses rr.
  always_comb begin
    set_valid = valid[set_idx];
    set_dirty = dirty[set_idx];
    hit       = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (set_valid[w] && tag_mem[set_idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    victim = rr[set_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) victim = WAY_W'(w);
    end
  end

  assign all_valid    = &set_valid;
  assign victim_dirty = set_valid[victim] & set_dirty[victim];
  assign rr_next      = WAY_W'((int'(rr[set_idx]) + 1) % WAYS);

  // Control state: FSM, valid/dirty/rr bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        rr[s]    <= '0;
      end
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      victim_q   <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) state <= S_LOOKUP;
        S_LOOKUP: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= we_q ? wdata_q : data_mem[set_idx][hit_way];
            if (we_q) dirty[set_idx][hit_way] <= 1'b1;
            state <= S_IDLE;
          end else begin
            victim_q <= victim;
            if (all_valid) rr[set_idx] <= rr_next;
            if (victim_dirty) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_mem[set_idx][victim], set_idx};
              mem_wdata <= data_mem[set_idx][victim];
              state     <= S_WB;
            end else begin
              state <= S_REFILL;
            end
          end
        end
        S_WB: if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= S_REFILL;
        end
        // Entered with mem_req low; it is raised here, which also gives the
        // mandatory idle cycle between a writeback and its refill.
        S_REFILL: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr_q;
          end else if (mem_ack) begin
            mem_req                   <= 1'b0;
            valid[set_idx][victim_q]  <= 1'b1;
            dirty[set_idx][victim_q]  <= we_q;
            resp_valid                <= 1'b1;
            resp_rdata                <= we_q ? wdata_q : mem_rdata;
            state                     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath storage: request capture, line data and tags (never reset).
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (state == S_LOOKUP && hit && we_q) data_mem[set_idx][hit_way] <= wdata_q;
    if (state == S_REFILL && mem_req && mem_ack) begin
      data_mem[set_idx][victim_q] <= we_q ? wdata_q : mem_rdata;
      tag_mem[set_idx][victim_q]  <= tag;
    end
  end

`ifdef CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbacks <= '0;
    end else begin
      if (state == S_LOOKUP && hit)  stat_hits   <= sat_inc(stat_hits);
      if (state == S_LOOKUP && !hit) stat_misses <= sat_inc(stat_misses);
      if (state == S_WB && mem_ack)  stat_wbacks <= sat_inc(stat_wbacks);
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Self-checking bench for set_assoc_wb_cache (default parameters).
// A transaction-level cache model predicts each response and the exact
// sequence of memory operations; a memory responder acks 3 cycles after
// mem_req rises and checks every operation against the prediction.
module tb_set_assoc_wb_cache;
  localparam int WAYS = 2;
  localparam int NSET = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic        req_ready;
  logic [16:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  set_assoc_wb_cache dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {bit we; logic [16:0] a; logic [31:0] d;} mem_op_t;
  mem_op_t exp_ops[$];

  // Reference cache state and memory images.
  bit          m_valid [NSET][WAYS];
  bit          m_dirty [NSET][WAYS];
  logic [8:0]  m_tag   [NSET][WAYS];
  logic [31:0] m_data  [NSET][WAYS];
  int          m_rr    [NSET];
  logic [31:0] model_mem [logic [16:0]];
  logic [31:0] phys_mem  [logic [16:0]];

  bit          hold = 1'b0;
  int          cnt = 0;
  int          wb_seen = 0;
  logic [16:0] last_ref_addr = '0, last_wb_addr = '0;
  logic [31:0] last_wb_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mm_rd(input logic [16:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return {15'h0, a};
  endfunction

  function automatic logic [31:0] ph_rd(input logic [16:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return {15'h0, a};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSET; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    end
  endtask

  // Predict one request: response word, hit flag, and queued memory ops.
  task automatic predict(input bit we, input logic [16:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output bit h);
    int s;
    int hw;
    int v;
    logic [8:0] t;
    mem_op_t op;
    s = int'(a[7:0]);
    t = a[16:8];
    hw = -1;
    v = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      h = 1;
      if (we) begin
        m_data[s][hw] = d;
        m_dirty[s][hw] = 1;
      end
      rd = m_data[s][hw];
    end else begin
      h = 0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[s][w]) v = w;
      if (v < 0) begin
        v = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      if (m_valid[s][v] && m_dirty[s][v]) begin
        op.we = 1;
        op.a = {m_tag[s][v], a[7:0]};
        op.d = m_data[s][v];
        exp_ops.push_back(op);
        model_mem[op.a] = op.d;
      end
      op.we = 0;
      op.a = a;
      op.d = '0;
      exp_ops.push_back(op);
      m_data[s][v] = we ? d : mm_rd(a);
      m_tag[s][v] = t;
      m_valid[s][v] = 1;
      m_dirty[s][v] = we;
      rd = m_data[s][v];
    end
  endtask

  // Memory responder: ack 3 cycles after mem_req rises, check every op.
  initial begin
    mem_op_t op;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
        chk("mem_req_drop_after_ack", {31'h0, mem_req}, 32'h0);
      end else if (mem_req && !hold) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          if (exp_ops.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_op_unexpected: got we=%0b addr=%h expected none", mem_we, mem_addr);
          end else begin
            op = exp_ops.pop_front();
            chk("mem_we", {31'h0, mem_we}, {31'h0, op.we});
            chk("mem_addr", {15'h0, mem_addr}, {15'h0, op.a});
            if (op.we) chk("mem_wdata", mem_wdata, op.d);
          end
          if (mem_we) begin
            phys_mem[mem_addr] = mem_wdata;
            wb_seen++;
            last_wb_addr = mem_addr;
            last_wb_data = mem_wdata;
          end else begin
            mem_rdata = ph_rd(mem_addr);
            last_ref_addr = mem_addr;
          end
          mem_ack = 1'b1;
        end
      end else if (!mem_req) begin
        cnt = 0;
      end
    end
  end

  // Issue one request, wait for its response and compare against the model.
  task automatic do_req(input bit we, input logic [16:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit dut_hit);
    logic [31:0] erd;
    bit eh;
    int edges;
    bit got;
    predict(we, a, d, erd, eh);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    edges = 0;
    while (!req_ready && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    rd = '0;
    dut_hit = 0;
    if (!req_ready) begin
      chk("accept_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = 17'($urandom);
    req_wdata = $urandom;
    chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
    got = 0;
    edges = 0;
    while (!got && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (resp_valid) begin
        got = 1;
        rd = resp_rdata;
      end
    end
    if (!got) begin
      chk("resp_timeout", {31'h0, resp_valid}, 32'h1);
      return;
    end
    dut_hit = (edges == 1);
    chk("resp_rdata", rd, erd);
    chk("hit_latency", {31'h0, dut_hit}, {31'h0, eh});
    chk("mem_ops_done", 32'(exp_ops.size()), 32'h0);
    @(posedge clk);
    #1;
    chk("resp_pulse", {31'h0, resp_valid}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] erd;
    logic [31:0] saved;
    bit h;
    bit eh;
    int wb0;
    int edges;
    int s;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {15'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);

    // 1: cold read miss.
    wb0 = wb_seen;
    do_req(0, 17'h00105, 0, rd, h);
    chk("t1_rdata", rd, 32'h00000105);
    chk("t1_miss", {31'h0, h}, 32'h0);
    chk("t1_refill_addr", {15'h0, last_ref_addr}, 32'h00105);
    chk("t1_no_wb", 32'(wb_seen - wb0), 32'h0);

    // 2: write hit then read hit.
    do_req(1, 17'h00105, 32'h0C0C0C0C, rd, h);
    chk("t2_write_hit", {31'h0, h}, 32'h1);
    chk("t2_write_resp", rd, 32'h0C0C0C0C);
    do_req(0, 17'h00105, 0, rd, h);
    chk("t2_read_hit", {31'h0, h}, 32'h1);
    chk("t2_read_data", rd, 32'h0C0C0C0C);

    // 3: fill way1, then evict the dirty way0.
    wb0 = wb_seen;
    do_req(0, 17'h00205, 0, rd, h);
    chk("t3_way1_data", rd, 32'h00000205);
    chk("t3_way1_no_wb", 32'(wb_seen - wb0), 32'h0);
    do_req(0, 17'h00305, 0, rd, h);
    chk("t3_evict_data", rd, 32'h00000305);
    chk("t3_wb_count", 32'(wb_seen - wb0), 32'h1);
    chk("t3_wb_addr", {15'h0, last_wb_addr}, 32'h00105);
    chk("t3_wb_data", last_wb_data, 32'h0C0C0C0C);

    // 4: write miss evicts clean way1 and merges.
    wb0 = wb_seen;
    do_req(1, 17'h00405, 32'h0A0A0A0A, rd, h);
    chk("t4_wmiss", {31'h0, h}, 32'h0);
    chk("t4_wmiss_resp", rd, 32'h0A0A0A0A);
    chk("t4_no_wb", 32'(wb_seen - wb0), 32'h0);
    do_req(0, 17'h00405, 0, rd, h);
    chk("t4_read_hit", {31'h0, h}, 32'h1);
    chk("t4_read_data", rd, 32'h0A0A0A0A);
    do_req(0, 17'h00105, 0, rd, h);
    chk("t4_refetch_miss", {31'h0, h}, 32'h0);
    chk("t4_refetch_data", rd, 32'h0C0C0C0C);

    // 5: reset in the middle of a writeback.
    saved = mm_rd(17'h00405);
    hold = 1'b1;
    predict(0, 17'h00505, 0, erd, eh);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 17'h00505;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    edges = 0;
    while (!(mem_req && mem_we) && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    chk("t5_wb_started", {31'h0, mem_req & mem_we}, 32'h1);
    chk("t5_wb_addr", {15'h0, mem_addr}, 32'h00405);
    chk("t5_wb_data", mem_wdata, 32'h0A0A0A0A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_mem_req", {31'h0, mem_req}, 32'h0);
    model_reset();
    exp_ops.delete();
    model_mem[17'h00405] = saved;
    @(negedge clk);
    @(negedge clk);
    cnt = 0;
    hold = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_req_ready", {31'h0, req_ready}, 32'h1);
    chk("t5_resp_valid", {31'h0, resp_valid}, 32'h0);
    do_req(0, 17'h00205, 0, rd, h);
    chk("t5_after_reset_miss", {31'h0, h}, 32'h0);
    chk("t5_after_reset_data", rd, 32'h00000205);

    // Randomized traffic concentrated on a few sets to force conflicts.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: s = 5;
        1: s = 9;
        2: s = 200;
        default: s = int'($urandom_range(0, 255));
      endcase
      do_req(1'($urandom), {9'($urandom_range(0, 4)), 8'(s)}, $urandom, rd, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
